// File: rtl/tx_sched_if.sv
// tx_sched_if: request/grant bundle between the channel requesters, the TX engine and the scheduler.
interface tx_sched_if #(
  parameter int C_NUM_CHNL = 12
) ();
  logic [C_NUM_CHNL-1:0] REQ_ALL;
  logic                  TLP_DONE;
  logic                  GNT_VALID;
  logic [3:0]            GNT_CHNL;
  logic [C_NUM_CHNL-1:0] GNT_ALL;
  modport master (
    output REQ_ALL, TLP_DONE,
    input  GNT_VALID, GNT_CHNL, GNT_ALL
  );
  modport slave (
    input  REQ_ALL, TLP_DONE,
    output GNT_VALID, GNT_CHNL, GNT_ALL
  );
endinterface

// File: rtl/tx_channel_scheduler.sv
// tx_channel_scheduler: round-robin owner of the shared TX engine across C_NUM_CHNL channels.
// Define TX_SCHED_QUANTUM_EN to cap each grant at C_QUANTUM TLPs.
module tx_channel_scheduler #(
  parameter int C_NUM_CHNL = 12,
  parameter int C_QUANTUM  = 8
) (
  input logic       CLK,
  input logic       RST,
  tx_sched_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  logic [1:0]            state;
  logic [3:0]            count;
  logic [3:0]            last;
  logic [3:0]            pick;
  logic [3:0]            idx;
  logic [4:0]            sum;
  logic [15:0]           reqExt;
  logic                  gntValid;
  logic [3:0]            gntChnl;
  logic [C_NUM_CHNL-1:0] gntAll;
  logic                  quantumHit;
  logic                  relGrant;
  if (C_NUM_CHNL < 1 || C_NUM_CHNL > 12 || C_QUANTUM < 1 || C_QUANTUM > 15) begin : gBadParam
    $error("tx_channel_scheduler: C_NUM_CHNL must be 1..12 and C_QUANTUM 1..15");
  end
  assign reqExt = 16'(bus.REQ_ALL);
  // Walk offsets from farthest to nearest so the channel just after last wins.
  always_comb begin
    pick = '0;
    sum  = '0;
    idx  = '0;
    for (int k = C_NUM_CHNL; k >= 1; k--) begin
      sum = {1'b0, last} + 5'(k);
      idx = sum >= 5'(C_NUM_CHNL) ? 4'(sum - 5'(C_NUM_CHNL)) : sum[3:0];
      if (reqExt[idx]) pick = idx;
    end
  end
`ifdef TX_SCHED_QUANTUM_EN
  assign quantumHit = bus.TLP_DONE && count == 4'(C_QUANTUM - 1);
`else
  assign quantumHit = 1'b0;
`endif
  assign relGrant = !reqExt[gntChnl] || quantumHit;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      last     <= 4'(C_NUM_CHNL - 1);
      gntValid <= 1'b0;
      gntChnl  <= '0;
      gntAll   <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.REQ_ALL) begin
          gntValid <= 1'b1;
          gntChnl  <= pick;
          gntAll   <= C_NUM_CHNL'(1) << pick;
          state    <= GRANT;
        end
        GRANT: begin
          if (bus.TLP_DONE && count != 4'hF) count <= count + 4'd1;
          if (relGrant) begin
            gntValid <= 1'b0;
            gntAll   <= '0;
            last     <= gntChnl;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.GNT_VALID = gntValid;
  assign bus.GNT_CHNL  = gntChnl;
  assign bus.GNT_ALL   = gntAll;
endmodule

// File: tb/tb_tx_channel_scheduler.sv
// tb_tx_channel_scheduler: directed checks of grant order, latency, release gap, wrap and reset.
module tb_tx_channel_scheduler;
  logic CLK = 1'b0;
  logic RST;
  int   tests  = 0;
  int   failed = 0;
  tx_sched_if #(.C_NUM_CHNL(12)) bus ();
  tx_channel_scheduler #(.C_NUM_CHNL(12), .C_QUANTUM(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chkGnt(input string tag, input logic v, input logic [3:0] c, input logic [11:0] a);
    check({tag, "_valid"}, 32'(bus.GNT_VALID), 32'(v));
    check({tag, "_chnl"}, 32'(bus.GNT_CHNL), 32'(c));
    check({tag, "_all"}, 32'(bus.GNT_ALL), 32'(a));
  endtask
  initial begin
    RST = 1'b1;
    bus.REQ_ALL  = '0;
    bus.TLP_DONE = 1'b0;
    step();
    step();
    chkGnt("reset", 1'b0, 4'd0, 12'h000);
    RST = 1'b0;
    step();
    // single request, one-cycle latency, no combinational path
    bus.REQ_ALL = 12'h001;
    #1;
    check("t1_nocomb", 32'(bus.GNT_VALID), 32'd0);
    step();
    chkGnt("t1_gnt", 1'b1, 4'd0, 12'h001);
    bus.REQ_ALL = 12'h000;
    step();
    chkGnt("t1_rel", 1'b0, 4'd0, 12'h000);
    step();
    // ch3 drops REQ together with its 3rd TLP_DONE; ch4 waits out the 2-cycle gap
    bus.REQ_ALL = 12'h008;
    step();
    chkGnt("t4_gnt", 1'b1, 4'd3, 12'h008);
    bus.TLP_DONE = 1'b1;
    step();
    step();
    bus.REQ_ALL = 12'h010;
    step();
    chkGnt("t4_rel", 1'b0, 4'd3, 12'h000);
    bus.TLP_DONE = 1'b0;
    step();
    chkGnt("t4_gap", 1'b0, 4'd3, 12'h000);
    step();
    chkGnt("t4_next", 1'b1, 4'd4, 12'h010);
    // wrap 11 -> 0 -> 11
    bus.REQ_ALL = 12'h801;
    step();
    check("w_rel4", 32'(bus.GNT_VALID), 32'd0);
    step();
    step();
    chkGnt("wrap11", 1'b1, 4'd11, 12'h800);
    bus.REQ_ALL = 12'h001;
    step();
    step();
    step();
    chkGnt("wrap0", 1'b1, 4'd0, 12'h001);
    bus.REQ_ALL = 12'h800;
    step();
    step();
    step();
    chkGnt("wrap11b", 1'b1, 4'd11, 12'h800);
    // reset mid-grant after 5 TLPs restores ch0 as first priority
    bus.REQ_ALL  = 12'h804;
    bus.TLP_DONE = 1'b1;
    repeat (5) step();
    bus.TLP_DONE = 1'b0;
    RST = 1'b1;
    step();
    chkGnt("rst_mid", 1'b0, 4'd0, 12'h000);
    RST = 1'b0;
    bus.REQ_ALL = 12'h00F;
    step();
    chkGnt("rst_ch0", 1'b1, 4'd0, 12'h001);
    bus.REQ_ALL = 12'h000;
    step();
    step();
`ifndef TX_SCHED_QUANTUM_EN
    // without the quantum, ch1 holds through 20 TLPs
    bus.REQ_ALL = 12'h012;
    step();
    chkGnt("t6_gnt", 1'b1, 4'd1, 12'h002);
    bus.TLP_DONE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t6_hold", {bus.GNT_VALID, bus.GNT_CHNL}, {1'b1, 4'd1});
    end
    bus.TLP_DONE = 1'b0;
    bus.REQ_ALL  = 12'h010;
    step();
    check("t6_rel", 32'(bus.GNT_VALID), 32'd0);
    step();
    step();
    chkGnt("t6_ch4", 1'b1, 4'd4, 12'h010);
`else
    // quantum of 8 rotates 2,5,7,2 with a 2-cycle gap after each
    begin
      logic [3:0] order [4] = '{4'd2, 4'd5, 4'd7, 4'd2};
      bus.REQ_ALL  = 12'h0A4;
      bus.TLP_DONE = 1'b1;
      for (int g = 0; g < 4; g++) begin
        for (int i = 0; i < 8; i++) begin
          step();
          check("q_hold", {bus.GNT_VALID, bus.GNT_CHNL}, {1'b1, order[g]});
        end
        for (int i = 0; i < 2; i++) begin
          step();
          check("q_gap", 32'(bus.GNT_VALID), 32'd0);
        end
      end
    end
    bus.REQ_ALL  = 12'h800;
    bus.TLP_DONE = 1'b0;
    step();
    chkGnt("q_w11", 1'b1, 4'd11, 12'h800);
    bus.REQ_ALL  = 12'h801;
    bus.TLP_DONE = 1'b1;
    repeat (7) step();
    check("q_w11_hold", {bus.GNT_VALID, bus.GNT_CHNL}, {1'b1, 4'd11});
    step();
    check("q_w11_rel", 32'(bus.GNT_VALID), 32'd0);
    step();
    step();
    chkGnt("q_w0", 1'b1, 4'd0, 12'h001);
    repeat (7) step();
    check("q_w0_hold", {bus.GNT_VALID, bus.GNT_CHNL}, {1'b1, 4'd0});
    step();
    check("q_w0_rel", 32'(bus.GNT_VALID), 32'd0);
    step();
    step();
    chkGnt("q_w11b", 1'b1, 4'd11, 12'h800);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
